// File: rtl/prbs_checker.sv
// prbs_checker: self-synchronising receive-side checker for the x^31 + x^3 + 1
// noise sequence. Fills a 31-bit history, searches for a run of correct
// predictions, then free-runs the reference and counts bit errors while locked.
module prbs_checker #(
    parameter int LOCK_COUNT     = 64,
    parameter int WINDOW         = 1024,
    parameter int LOSS_THRESHOLD = 8,
    parameter int ERR_W          = 16,
    parameter int BIT_W          = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             bit_in,
    input  logic             bit_valid,
    input  logic             clr_counts,
    output logic             locked,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_count,
    output logic [BIT_W-1:0] bit_count
);

    localparam int MATCH_W = $clog2(LOCK_COUNT + 1);
    localparam int WIN_W   = $clog2(WINDOW + 1);
    localparam int WERR_W  = $clog2(LOSS_THRESHOLD + 1);

    typedef enum logic [1:0] {
        ST_FILL   = 2'd0,
        ST_SEARCH = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    state_t             state_reg, state_next;
    logic [30:0]        hist_reg, hist_next;
    logic [4:0]         fill_cnt_reg, fill_cnt_next;
    logic [MATCH_W-1:0] match_cnt_reg, match_cnt_next;
    logic [WIN_W-1:0]   win_cnt_reg, win_cnt_next;
    logic [WERR_W-1:0]  win_err_reg, win_err_next;
    logic [ERR_W-1:0]   err_count_reg, err_count_next;
    logic [BIT_W-1:0]   bit_count_reg, bit_count_next;
    logic               err_pulse_reg, err_pulse_next;
    logic               locked_reg;

    // Prediction from the recurrence x[n] = x[n-3] ^ x[n-31]; hist[0] is newest.
    logic predict;
    logic mismatch;
    logic hist_zero;
    logic fill_done;
    logic lock_hit;
    logic loss_hit;
    logic win_end;

    assign predict   = hist_reg[2] ^ hist_reg[30];
    assign mismatch  = bit_in != predict;
    assign hist_zero = hist_reg == '0;
    assign fill_done = fill_cnt_reg == 5'd30;
    assign lock_hit  = match_cnt_reg == MATCH_W'(LOCK_COUNT - 1);
    assign loss_hit  = win_err_reg == WERR_W'(LOSS_THRESHOLD - 1);
    assign win_end   = win_cnt_reg == WIN_W'(WINDOW - 1);

    // State register plus all datapath registers, synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_FILL;
            hist_reg      <= '0;
            fill_cnt_reg  <= '0;
            match_cnt_reg <= '0;
            win_cnt_reg   <= '0;
            win_err_reg   <= '0;
            err_count_reg <= '0;
            bit_count_reg <= '0;
            err_pulse_reg <= 1'b0;
            locked_reg    <= 1'b0;
        end else begin
            state_reg     <= state_next;
            hist_reg      <= hist_next;
            fill_cnt_reg  <= fill_cnt_next;
            match_cnt_reg <= match_cnt_next;
            win_cnt_reg   <= win_cnt_next;
            win_err_reg   <= win_err_next;
            err_count_reg <= err_count_next;
            bit_count_reg <= bit_count_next;
            err_pulse_reg <= err_pulse_next;
            locked_reg    <= state_next == ST_LOCKED;
        end
    end

    // Next-state logic; nothing moves without a strobe.
    always_comb begin
        state_next = state_reg;
        if (bit_valid) begin
            case (state_reg)
                ST_FILL:   if (fill_done) state_next = ST_SEARCH;
                ST_SEARCH: if (!mismatch && !hist_zero && lock_hit) state_next = ST_LOCKED;
                ST_LOCKED: if (mismatch && loss_hit) state_next = ST_FILL;
                default:   state_next = ST_FILL;
            endcase
        end
    end

    // Datapath and output next values per state; clr_counts overrides increments.
    always_comb begin
        hist_next      = hist_reg;
        fill_cnt_next  = fill_cnt_reg;
        match_cnt_next = match_cnt_reg;
        win_cnt_next   = win_cnt_reg;
        win_err_next   = win_err_reg;
        err_count_next = err_count_reg;
        bit_count_next = bit_count_reg;
        err_pulse_next = 1'b0;
        if (bit_valid) begin
            case (state_reg)
                ST_FILL: begin
                    hist_next      = {hist_reg[29:0], bit_in};
                    fill_cnt_next  = fill_done ? 5'd0 : fill_cnt_reg + 5'd1;
                    match_cnt_next = '0;
                end
                ST_SEARCH: begin
                    hist_next = {hist_reg[29:0], bit_in};
                    // An all-zero history is a trivial fixed point and must not lock.
                    if (!mismatch && !hist_zero)
                        match_cnt_next = match_cnt_reg + MATCH_W'(1);
                    else
                        match_cnt_next = '0;
                    win_cnt_next = '0;
                    win_err_next = '0;
                end
                ST_LOCKED: begin
                    // Reference runs free so a single flipped bit costs one error.
                    hist_next = {hist_reg[29:0], predict};
                    if (bit_count_reg != '1)
                        bit_count_next = bit_count_reg + BIT_W'(1);
                    if (mismatch) begin
                        err_pulse_next = 1'b1;
                        if (err_count_reg != '1)
                            err_count_next = err_count_reg + ERR_W'(1);
                    end
                    // Loss check takes priority over the window rollover.
                    if (mismatch && loss_hit) begin
                        fill_cnt_next  = '0;
                        match_cnt_next = '0;
                        win_cnt_next   = '0;
                        win_err_next   = '0;
                    end else if (win_end) begin
                        win_cnt_next = '0;
                        win_err_next = '0;
                    end else begin
                        win_cnt_next = win_cnt_reg + WIN_W'(1);
                        if (mismatch)
                            win_err_next = win_err_reg + WERR_W'(1);
                    end
                end
                default: ;
            endcase
        end
        if (clr_counts) begin
            err_count_next = '0;
            bit_count_next = '0;
        end
    end

    assign locked    = locked_reg;
    assign err_pulse = err_pulse_reg;
    assign err_count = err_count_reg;
    assign bit_count = bit_count_reg;

endmodule

// File: tb/tb_prbs_checker.sv
// tb_prbs_checker: directed tests for prbs_checker. Two instances share all
// inputs; the second uses a 4-bit error counter to exercise saturation.
module tb_prbs_checker;

    logic        clk = 1'b0;
    logic        rst;
    logic        bit_in;
    logic        bit_valid;
    logic        clr_counts;
    logic        locked, err_pulse;
    logic [15:0] err_count;
    logic [31:0] bit_count;
    logic        locked_s, err_pulse_s;
    logic [3:0]  err_count_s;
    logic [31:0] bit_count_s;

    int          tests = 0;
    int          fails = 0;
    int          pulses = 0;
    logic [30:0] gen;

    prbs_checker dut (
        .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid),
        .clr_counts(clr_counts), .locked(locked), .err_pulse(err_pulse),
        .err_count(err_count), .bit_count(bit_count)
    );

    prbs_checker #(.ERR_W(4)) dut_sat (
        .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid),
        .clr_counts(clr_counts), .locked(locked_s), .err_pulse(err_pulse_s),
        .err_count(err_count_s), .bit_count(bit_count_s)
    );

    always #5 clk = ~clk;

    // Count error pulses of the main instance, sampled mid-cycle.
    always @(negedge clk) if (err_pulse) pulses++;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
        end else begin
            $display("[TB] ok   %s = %0d", tag, got);
        end
    endtask

    task automatic send_raw(input logic b);
        bit_in    = b;
        bit_valid = 1'b1;
        @(posedge clk);
        #1;
        bit_valid = 1'b0;
    endtask

    // Next generator bit, optionally inverted on the wire.
    task automatic send(input logic flip);
        logic b;
        b   = gen[2] ^ gen[30];
        gen = {gen[29:0], b};
        send_raw(b ^ flip);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        int   p0;
        logic any_lock;
        rst        = 1'b1;
        bit_in     = 1'b0;
        bit_valid  = 1'b0;
        clr_counts = 1'b0;
        gen        = 31'h608420dd;
        idle(2);
        rst = 1'b0;
        check("reset_locked", locked, 1'b0);
        check("reset_err_pulse", err_pulse, 1'b0);
        check("reset_err_count", err_count, 0);
        check("reset_bit_count", bit_count, 0);

        // Clean lock over 10000 bits.
        p0 = pulses;
        for (int i = 1; i <= 10000; i++) begin
            send(1'b0);
            if (i == 94) check("clean_lock_94", locked, 1'b0);
            if (i == 95) check("clean_lock_95", locked, 1'b1);
        end
        check("clean_err_count", err_count, 0);
        check("clean_pulses", pulses - p0, 0);
        check("clean_bit_count", bit_count, 9905);

        // Single flipped bit at post-lock position 500.
        p0 = pulses;
        for (int i = 1; i <= 499; i++) send(1'b0);
        send(1'b1);
        check("single_err_pulse", err_pulse, 1'b1);
        for (int i = 1; i <= 1100; i++) send(1'b0);
        check("single_pulses", pulses - p0, 1);
        check("single_err_count", err_count, 1);
        check("single_locked", locked, 1'b1);
        check("single_bit_count", bit_count, 9905 + 1600);

        // Burst of 8 errors forces loss, then relock.
        clr_counts = 1'b1;
        idle(1);
        clr_counts = 1'b0;
        check("clr_err_count", err_count, 0);
        check("clr_bit_count", bit_count, 0);
        for (int i = 1; i <= 8; i++) begin
            send(1'b1);
            if (i == 7) check("burst_locked_7", locked, 1'b1);
        end
        check("burst_locked_8", locked, 1'b0);
        check("burst_err_count", err_count, 8);
        check("burst_bit_count", bit_count, 8);
        for (int i = 1; i <= 94; i++) send(1'b0);
        check("relock_94", locked, 1'b0);
        check("relock_bit_count_94", bit_count, 8);
        send(1'b0);
        check("relock_95", locked, 1'b1);
        check("relock_bit_count_95", bit_count, 8);

        // Stuck-low then stuck-high input never locks.
        do_reset();
        any_lock = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            send_raw(1'b0);
            any_lock |= locked;
        end
        check("stuck_low_locked", any_lock, 1'b0);
        for (int i = 0; i < 2000; i++) begin
            send_raw(1'b1);
            any_lock |= locked;
        end
        check("stuck_high_locked", any_lock, 1'b0);

        // Reset while locked.
        do_reset();
        for (int i = 1; i <= 95; i++) send(1'b0);
        check("pre_rst_locked", locked, 1'b1);
        send(1'b1);
        for (int i = 1; i <= 10; i++) send(1'b0);
        check("pre_rst_err_count", err_count, 1);
        check("pre_rst_bit_count", bit_count, 11);
        do_reset();
        check("rst_locked", locked, 1'b0);
        check("rst_err_count", err_count, 0);
        check("rst_bit_count", bit_count, 0);
        for (int i = 1; i <= 94; i++) send(1'b0);
        check("rst_relock_94", locked, 1'b0);
        send(1'b0);
        check("rst_relock_95", locked, 1'b1);

        // Sparse strobes.
        do_reset();
        for (int i = 1; i <= 95; i++) begin
            idle(12);
            send(1'b0);
            if (i == 94) check("sparse_lock_94", locked, 1'b0);
            if (i == 95) check("sparse_lock_95", locked, 1'b1);
        end

        // clr_counts colliding with an error.
        for (int i = 1; i <= 5; i++) send(1'b0);
        check("collide_pre_bit_count", bit_count, 5);
        clr_counts = 1'b1;
        send(1'b1);
        clr_counts = 1'b0;
        check("collide_err_pulse", err_pulse, 1'b1);
        check("collide_err_count", err_count, 0);
        check("collide_bit_count", bit_count, 0);
        send(1'b0);
        check("collide_next_pulse", err_pulse, 1'b0);
        check("collide_next_bit_count", bit_count, 1);

        // 20 isolated errors: 4-bit counter saturates at 15.
        do_reset();
        for (int i = 1; i <= 95; i++) send(1'b0);
        for (int k = 0; k < 20; k++) begin
            send(1'b1);
            for (int i = 0; i < 1100; i++) send(1'b0);
        end
        check("sat_err_count_w4", err_count_s, 15);
        check("sat_err_count_w16", err_count, 20);
        check("sat_locked_w4", locked_s, 1'b1);
        check("sat_locked_w16", locked, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
